// File: rtl/rv_perf_monitor.sv
// Performance monitor for the rv32i pipeline: shadows D/E/M/W validity, counts
// cycles/retirements/flushes/load-use bubbles, detects program end and computes CPI.
module rv_perf_monitor #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned HALT_WIN = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             instr_f,
    input  logic [31:0]             pc_f,
    input  logic                    stall_d,
    input  logic                    flush_d,
    input  logic                    flush_e,
    output logic [CNT_W-1:0]        cycle_cnt_o,
    output logic [CNT_W-1:0]        instr_cnt_o,
    output logic [CNT_W-1:0]        flush_cnt_o,
    output logic [CNT_W-1:0]        bubble_cnt_o,
    output logic                    halted_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_W+FRAC-1:0]   cpi_o,
    output logic                    div0_o
);

    localparam int unsigned QW     = CNT_W + FRAC;
    localparam int unsigned ZR_W   = $clog2(HALT_WIN + 1);
    localparam int unsigned STEP_W = $clog2(QW + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ZR_W-1:0]   ZR_ONE   = ZR_W'(1);
    localparam logic [ZR_W-1:0]   ZR_MAX   = ZR_W'(HALT_WIN);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_END = STEP_W'(QW - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DIV,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               vd_q, vd_d;
    logic               ve_q, ve_d;
    logic               vm_q, vm_d;
    logic               vw_q, vw_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
    logic [ZR_W-1:0]    zr_q, zr_d;
    logic [31:0]        pc_prev_q, pc_prev_d;
    logic               halted_q, halted_d;
    logic               div0_q, div0_d;
    logic [QW-1:0]      cpi_q, cpi_d;
    logic [QW-1:0]      dvd_q, dvd_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [STEP_W-1:0]  step_q, step_d;

    logic [CNT_W:0]     rem_sh;
    logic               q_bit;
    logic [CNT_W-1:0]   rem_sub;
    logic [QW-1:0]      dvd_nx;
    logic               pipe_empty;
    logic               halt_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    // One restoring-division step; the dividend register shifts quotient bits in at the LSB.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[QW-1]};
        q_bit   = (rem_sh >= {1'b0, instr_cnt_q});
        rem_sub = q_bit ? (rem_sh[CNT_W-1:0] - instr_cnt_q) : rem_sh[CNT_W-1:0];
        dvd_nx  = {dvd_q[QW-2:0], q_bit};
    end

    assign pipe_empty = !(vd_q | ve_q | vm_q | vw_q);
    assign halt_now   = (zr_q == ZR_MAX) && pipe_empty;

    always_comb begin
        state_d      = state_q;
        vd_d         = vd_q;
        ve_d         = ve_q;
        vm_d         = vm_q;
        vw_d         = vw_q;
        cycle_cnt_d  = cycle_cnt_q;
        instr_cnt_d  = instr_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        halted_d     = halted_q;
        div0_d       = div0_q;
        cpi_d        = cpi_q;
        dvd_d        = dvd_q;
        rem_d        = rem_q;
        step_d       = step_q;
        pc_prev_d    = pc_f;

        if ((instr_f == 32'd0) && (pc_f == pc_prev_q)) begin
            zr_d = (zr_q == ZR_MAX) ? zr_q : zr_q + ZR_ONE;
        end else begin
            zr_d = '0;
        end

        case (state_q)
            S_RUN: begin
                if (halt_now) begin
                    state_d  = S_DIV;
                    halted_d = 1'b1;
                    dvd_d    = {cycle_cnt_q, {FRAC{1'b0}}};
                    rem_d    = '0;
                    step_d   = '0;
                end else begin
                    cycle_cnt_d  = sat_inc(cycle_cnt_q, 1'b1);
                    instr_cnt_d  = sat_inc(instr_cnt_q, vw_q);
                    flush_cnt_d  = sat_inc(flush_cnt_q, flush_d);
                    bubble_cnt_d = sat_inc(bubble_cnt_q, stall_d & flush_e);
                    vd_d = flush_d ? 1'b0 : (stall_d ? vd_q : (instr_f != 32'd0));
                    ve_d = flush_e ? 1'b0 : vd_q;
                    vm_d = ve_q;
                    vw_d = vm_q;
                end
            end
            S_DIV: begin
                if (instr_cnt_q == '0) begin
                    cpi_d   = '1;
                    div0_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dvd_d  = dvd_nx;
                    rem_d  = rem_sub;
                    step_d = step_q + STEP_ONE;
                    if (step_q == STEP_END) begin
                        cpi_d   = dvd_nx;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_RUN;
            vd_q         <= 1'b0;
            ve_q         <= 1'b0;
            vm_q         <= 1'b0;
            vw_q         <= 1'b0;
            cycle_cnt_q  <= '0;
            instr_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            zr_q         <= '0;
            pc_prev_q    <= '0;
            halted_q     <= 1'b0;
            div0_q       <= 1'b0;
            cpi_q        <= '0;
            dvd_q        <= '0;
            rem_q        <= '0;
            step_q       <= '0;
        end else begin
            state_q      <= state_d;
            vd_q         <= vd_d;
            ve_q         <= ve_d;
            vm_q         <= vm_d;
            vw_q         <= vw_d;
            cycle_cnt_q  <= cycle_cnt_d;
            instr_cnt_q  <= instr_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            zr_q         <= zr_d;
            pc_prev_q    <= pc_prev_d;
            halted_q     <= halted_d;
            div0_q       <= div0_d;
            cpi_q        <= cpi_d;
            dvd_q        <= dvd_d;
            rem_q        <= rem_d;
            step_q       <= step_d;
        end
    end

    assign cycle_cnt_o  = cycle_cnt_q;
    assign instr_cnt_o  = instr_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
    assign halted_o     = halted_q;
    assign busy_o       = (state_q == S_DIV);
    assign done_o       = (state_q == S_DONE);
    assign cpi_o        = cpi_q;
    assign div0_o       = div0_q;

endmodule

// File: tb/tb_rv_perf_monitor.sv
// Directed + randomized bench for rv_perf_monitor against a queue-based pipeline model.
module tb_rv_perf_monitor;

    localparam int unsigned HW  = 5;
    localparam longint      CAP = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_f = '0;
    logic [31:0] pc_f = '0;
    logic        stall_d = 1'b0, flush_d = 1'b0, flush_e = 1'b0;

    logic [31:0] cyc_b, ins_b, fl_b, bub_b;
    logic        halt_b, busy_b, done_b, div0_b;
    logic [39:0] cpi_b;
    logic [7:0]  cyc_s, ins_s, fl_s, bub_s;
    logic        halt_s, busy_s, done_s, div0_s;
    logic [15:0] cpi_s;

    always #5 clk = ~clk;

    rv_perf_monitor #(.CNT_W(32), .FRAC(8), .HALT_WIN(HW)) u_big (
        .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f),
        .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .cycle_cnt_o(cyc_b), .instr_cnt_o(ins_b), .flush_cnt_o(fl_b), .bubble_cnt_o(bub_b),
        .halted_o(halt_b), .busy_o(busy_b), .done_o(done_b), .cpi_o(cpi_b), .div0_o(div0_b)
    );

    rv_perf_monitor #(.CNT_W(8), .FRAC(8), .HALT_WIN(HW)) u_small (
        .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f),
        .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .cycle_cnt_o(cyc_s), .instr_cnt_o(ins_s), .flush_cnt_o(fl_s), .bubble_cnt_o(bub_s),
        .halted_o(halt_s), .busy_o(busy_s), .done_o(done_s), .cpi_o(cpi_s), .div0_o(div0_s)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: the in-flight slots form a queue, front = decode, back = writeback.
    bit          mq[$];
    longint      m_cyc, m_ins, m_fl, m_bub;
    int          m_zr;
    logic [31:0] m_pcp;
    bit          m_halt;

    function automatic longint sat(input longint v, input longint cap);
        return (v > cap) ? cap : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq = '{0, 0, 0, 0};
        m_cyc = 0; m_ins = 0; m_fl = 0; m_bub = 0;
        m_zr = 0; m_pcp = '0; m_halt = 0;
    endtask

    task automatic model_edge();
        bit dnew, enew;
        if (!reset) begin
            model_reset();
        end else begin
            if (!m_halt) begin
                if (m_zr == HW && !(mq[0] | mq[1] | mq[2] | mq[3])) begin
                    m_halt = 1;
                end else begin
                    m_cyc = sat(m_cyc + 1, CAP);
                    m_ins = sat(m_ins + longint'(mq[3]), CAP);
                    m_fl  = sat(m_fl + longint'(flush_d), CAP);
                    m_bub = sat(m_bub + longint'(stall_d & flush_e), CAP);
                    dnew = flush_d ? 1'b0 : (stall_d ? mq[0] : (instr_f != 0));
                    enew = flush_e ? 1'b0 : mq[0];
                    void'(mq.pop_back());
                    mq[0] = enew;
                    mq.push_front(dnew);
                end
            end
            m_zr  = (instr_f == 0 && pc_f == m_pcp) ? ((m_zr < HW) ? m_zr + 1 : HW) : 0;
            m_pcp = pc_f;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fd, input logic fe);
        instr_f = ins; pc_f = pc; stall_d = st; flush_d = fd; flush_e = fe;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        instr_f = '0; pc_f = '0; stall_d = 0; flush_d = 0; flush_e = 0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic check_counters(input string p);
        check({p, "_cyc"},    64'(cyc_b),  64'(m_cyc));
        check({p, "_instr"},  64'(ins_b),  64'(m_ins));
        check({p, "_flush"},  64'(fl_b),   64'(m_fl));
        check({p, "_bubble"}, 64'(bub_b),  64'(m_bub));
        check({p, "_halted"}, 64'(halt_b), 64'(m_halt));
    endtask

    // Feed the zero word at a fixed PC until the big instance reports done.
    task automatic finish_run(input string p, input logic [31:0] pc_hold);
        int     nbusy = 0;
        bit     early = 0;
        longint exp_cpi;
        drive(32'd0, pc_hold, 0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            if (busy_b) nbusy++;
            if (!done_b && cpi_b != 0) early = 1;
            if (done_b) break;
            tick();
        end
        check({p, "_done"}, 64'(done_b), 64'd1);
        check({p, "_cpi_early"}, 64'(early), 64'd0);
        check({p, "_busy_cycles"}, 64'(nbusy), (m_ins == 0) ? 64'd1 : 64'd40);
        exp_cpi = (m_ins == 0) ? 64'hFF_FFFF_FFFF : (m_cyc * 256) / m_ins;
        check({p, "_cpi"}, 64'(cpi_b), 64'(exp_cpi));
        check({p, "_div0"}, 64'(div0_b), 64'(m_ins == 0));
        check_counters(p);
    endtask

    logic [31:0] words[10];
    logic [31:0] cyc1;

    initial begin
        model_reset();
        for (int i = 0; i < 10; i++) words[i] = ($urandom & 32'hFFFF_FF00) | 32'(i + 1);

        do_reset();
        check("rst_cyc", 64'(cyc_b), 64'd0);
        check("rst_instr", 64'(ins_b), 64'd0);
        check("rst_state", 64'({halt_b, busy_b, done_b, div0_b}), 64'd0);
        check("rst_cpi", 64'(cpi_b), 64'd0);

        // Clean stream of ten instructions
        for (int i = 0; i < 10; i++) drive(words[i], 32'(4 * i), 0, 0, 0);
        finish_run("s1", 32'd36);
        check("s1_instr10", 64'(ins_b), 64'd10);
        cyc1 = cyc_b;

        // Mispredict while instruction 3 sits in decode
        do_reset();
        for (int i = 0; i < 10; i++) drive(words[i], 32'(4 * i), 0, (i == 4), (i == 4));
        finish_run("s2", 32'd36);
        check("s2_instr8", 64'(ins_b), 64'd8);
        check("s2_flush1", 64'(fl_b), 64'd1);

        // Load-use bubble: fetch holds instruction 5 for one extra cycle
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i == 5) drive(words[i], 32'(4 * i), 1, 0, 1);
            drive(words[i], 32'(4 * i), 0, 0, 0);
        end
        finish_run("s3", 32'd36);
        check("s3_bubble1", 64'(bub_b), 64'd1);
        check("s3_instr10", 64'(ins_b), 64'd10);
        check("s3_cyc_plus1", 64'(cyc_b), 64'(cyc1) + 64'd1);

        // Zero word at a stable PC from reset release
        do_reset();
        finish_run("s4", 32'h100);
        check("s4_cpi_ones", 64'(cpi_b), 64'hFF_FFFF_FFFF);

        // Zero word with the PC moving every cycle never halts
        begin
            bit saw_halt = 0;
            do_reset();
            for (int i = 0; i < 50; i++) begin
                drive(32'd0, 32'(4 * i), 0, 0, 0);
                if (halt_b || busy_b) saw_halt = 1;
            end
            check("s5_no_halt", 64'(saw_halt), 64'd0);
            check("s5_cyc50", 64'(cyc_b), 64'd50);
            check_counters("s5");
        end

        // Randomized streams with arbitrary hazard combinations
        for (int r = 0; r < 3; r++) begin
            logic [31:0] pc = '0;
            do_reset();
            for (int i = 0; i < 80; i++) begin
                logic [31:0] w;
                logic st, fd, fe;
                w  = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'd1);
                st = ($urandom_range(0, 5) == 0);
                fd = ($urandom_range(0, 7) == 0);
                fe = fd | ($urandom_range(0, 5) == 0);
                drive(w, pc, st, fd, fe);
                if (!st) pc = pc + 32'd4;
            end
            finish_run($sformatf("rnd%0d", r), pc);
        end

        // Narrow counters saturate; reset lands in the middle of the divide
        begin
            int nb = 0;
            do_reset();
            for (int i = 0; i < 300; i++) drive($urandom | 32'd1, 32'(4 * i), 0, 0, 0);
            drive(32'd0, 32'd1196, 0, 0, 0);
            for (int k = 0; k < 200 && nb < 5; k++) begin
                if (busy_s) nb++;
                if (nb < 5) tick();
            end
            check("s6_busy_seen", 64'(nb), 64'd5);
            check("s6_cyc_sat", 64'(cyc_s), 64'(sat(m_cyc, 255)));
            check("s6_cyc255", 64'(cyc_s), 64'd255);
            check("s6_instr_sat", 64'(ins_s), 64'(sat(m_ins, 255)));
            check("s6_cpi_hidden", 64'(cpi_s), 64'd0);
            reset = 1'b0;
            tick();
            check("s6_rst_cnts", 64'({cyc_s, ins_s, fl_s, bub_s}), 64'd0);
            check("s6_rst_flags", 64'({halt_s, busy_s, done_s, div0_s}), 64'd0);
            check("s6_rst_cpi", 64'(cpi_s), 64'd0);
            reset = 1'b1;
            drive(32'h13, 32'd0, 0, 0, 0);
            check("s6_run_cyc1", 64'(cyc_s), 64'd1);
            check("s6_run_idle", 64'({busy_s, done_s, halt_s}), 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
